// File: rtl/modexp_loader_pkg.sv
// Shared types and sizing for the ModExp input loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modexp_loader_pkg;

    // Operand geometry defaults: 4096-bit operand split into 128-bit words.
    localparam int DATA_WIDTH_DEF = 128;
    localparam int NUM_WORDS_DEF  = 32;

    // Delay counter width; also reused to time the post-burst gap.
    localparam int DLY_W = 16;

    // Loader sequencing states, IDLE encoded as zero so reset is all-zeros.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        PULSE   = 3'd2,
        SEND    = 3'd3,
        GAP     = 3'd4,
        FLUSH   = 3'd5,
        COMPUTE = 3'd6,
        RESULT  = 3'd7
    } state_t;

    // Word counter must reach NUM_WORDS itself without wrapping.
    function automatic int cntWidth(input int numWords);
        return $clog2(numWords) + 1;
    endfunction

endpackage

// File: rtl/modexp_loader_if.sv
// Host operand stream into the loader (valid/ready).
// Latency: n/a (wires only).
// Backpressure: sValid held by master until s_ready is seen high at a clock edge.
interface modexp_loader_if
    import modexp_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/modexp_word_buf.sv
// Operand word store: one synchronous write port, one combinational read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; caller gates wrEn.
module modexp_word_buf #(
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WORDS  = 32,
    parameter int AW         = 5
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [AW-1:0]         wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [AW-1:0]         rdAddr,
    output logic [DATA_WIDTH-1:0] rdData
);
    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];
endmodule

// File: rtl/modexp_loader.sv
// Buffers NUM_WORDS host words, then replays the ModExp input sequence with exact timing.
// Latency: startInput 1 cycle after last fill handshake; getResult RESULT_DELAY cycles after startCompute.
// Backpressure: s_ready high only in FILL; getResult held until ack. Macro MODEXP_LOADER_WORD_REVERSE_EN sends MS word first.
module modexp_loader
    import modexp_loader_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int NUM_WORDS    = NUM_WORDS_DEF,
    parameter int GAP_CYCLES   = 1,
    parameter int RESULT_DELAY = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    modexp_loader_if.slave        host,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic                  startInput,
    output logic                  startCompute,
    output logic                  getResult,
    output logic [DATA_WIDTH-1:0] inp
);
    localparam int CntW  = cntWidth(NUM_WORDS);
    localparam int AddrW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CntW-1:0]  LastIdx  = CntW'(NUM_WORDS - 1);
    localparam logic [CntW-1:0]  AllSent  = CntW'(NUM_WORDS);
    localparam logic [DLY_W-1:0] GapLast  = DLY_W'(GAP_CYCLES - 1);
    localparam logic [DLY_W-1:0] DlyLast  = DLY_W'(RESULT_DELAY - 1);

    state_t                state;
    logic [CntW-1:0]       cnt;
    logic [DLY_W-1:0]      dly;
    logic                  wrEn;
    logic [AddrW-1:0]      wrAddr;
    logic [AddrW-1:0]      rdIdx;
    logic [AddrW-1:0]      rdAddr;
    logic [DATA_WIDTH-1:0] rdData;

    assign host.s_ready = (state == FILL);
    assign busy         = (state != IDLE);
    assign wrEn         = (state == FILL) && host.s_valid;
    assign wrAddr       = cnt[AddrW-1:0];

    // Read index: word 0 is fetched during PULSE, then cnt walks the burst.
    always_comb begin
        rdIdx = (state == PULSE) ? '0 : cnt[AddrW-1:0];
`ifdef MODEXP_LOADER_WORD_REVERSE_EN
        rdAddr = AddrW'(NUM_WORDS - 1) - rdIdx;
`else
        rdAddr = rdIdx;
`endif
    end

    modexp_word_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .AW         (AddrW)
    ) u_buf (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrAddr),
        .wrData (host.s_data),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

    // Sequencer: state plus registered ModExp strobes and the inp output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            dly          <= '0;
            startInput   <= 1'b0;
            startCompute <= 1'b0;
            getResult    <= 1'b0;
            done         <= 1'b0;
            inp          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        state <= FILL;
                        cnt   <= '0;
                    end
                end
                FILL: begin
                    if (host.s_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LastIdx) begin
                            state      <= PULSE;
                            startInput <= 1'b1;
                            inp        <= '0;
                        end
                    end
                end
                PULSE: begin
                    startInput <= 1'b0;
                    inp        <= rdData;
                    cnt        <= CntW'(1);
                    state      <= SEND;
                end
                SEND: begin
                    if (cnt == AllSent) begin
                        dly <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= FLUSH;
                            inp   <= '0;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        inp <= rdData;
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (dly == GapLast) begin
                        state <= FLUSH;
                        inp   <= '0;
                    end else begin
                        dly <= dly + 1'b1;
                    end
                end
                FLUSH: begin
                    state        <= COMPUTE;
                    startCompute <= 1'b1;
                    dly          <= '0;
                end
                COMPUTE: begin
                    if (dly == DlyLast) begin
                        state     <= RESULT;
                        getResult <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        dly <= dly + 1'b1;
                    end
                end
                RESULT: begin
                    if (ack) begin
                        state        <= IDLE;
                        startCompute <= 1'b0;
                        getResult    <= 1'b0;
                        done         <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modexp_loader.sv
// Self-checking bench for modexp_loader: table of transactions plus a mid-burst reset sequence.
// Latency: n/a.
// Backpressure: host stream driven with and without stalls.
module tb_modexp_loader;
    localparam int DW  = 128;
    localparam int NW  = 32;
    localparam int GAP = 1;
    localparam int RD  = 100;
    localparam int LAT = 1 + NW + GAP + 1 + RD;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic          ack = 1'b0;
    logic          busy, done, startInput, startCompute, getResult;
    logic [DW-1:0] inp;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        bit           stall;
        logic [119:0] hi;
        int           ackHold;
        bit           noise;
        bit           goWithAck;
        int           expFill;
        int           expLat;
    } vec_t;

    vec_t vecs [4];

    modexp_loader_if #(.DATA_WIDTH(DW)) hostIf ();

    modexp_loader #(
        .DATA_WIDTH   (DW),
        .NUM_WORDS    (NW),
        .GAP_CYCLES   (GAP),
        .RESULT_DELAY (RD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .host         (hostIf),
        .ack          (ack),
        .busy         (busy),
        .done         (done),
        .startInput   (startInput),
        .startCompute (startCompute),
        .getResult    (getResult),
        .inp          (inp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] wordOf(input logic [119:0] hi, input int k);
        return {hi, 8'(k + 1)};
    endfunction

    // Buffer index expected on the wire in burst cycle k.
    function automatic int expIdx(input int k);
`ifdef MODEXP_LOADER_WORD_REVERSE_EN
        return NW - 1 - k;
`else
        return k;
`endif
    endfunction

    // Issue go, then push NW words; returns the number of FILL cycles used.
    task automatic doFill(input bit stall, input logic [119:0] hi, output int cyc);
        int   wrote;
        bit   v;
        logic rdy;
        wrote = 0;
        cyc   = 0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        while (wrote < NW && cyc < 4 * NW) begin
            v = stall ? (cyc % 2 == 0) : 1'b1;
            hostIf.s_valid = v;
            hostIf.s_data  = wordOf(hi, wrote);
            rdy = hostIf.s_ready;
            @(negedge clk);
            if (v && rdy) wrote++;
            cyc++;
        end
        hostIf.s_valid = 1'b0;
        hostIf.s_data  = '0;
        check("fill_words", wrote, NW);
    endtask

    task automatic runTxn(input vec_t v);
        int fillCyc;
        int n;
        int tStart;
        doFill(v.stall, v.hi, fillCyc);
        check("fill_cycles", fillCyc, v.expFill);
        check("start_pulse", startInput, 1'b1);
        check("pulse_inp", inp, '0);
        check("ready_drop", hostIf.s_ready, 1'b0);
        tStart = cycle;
        @(negedge clk);
        for (int k = 0; k < NW; k++) begin
            if (v.noise) begin
                if (k == 0) begin
                    hostIf.s_valid = 1'b1;
                    hostIf.s_data  = '1;
                end
                go = (k == 5);
            end
            check("send_word", inp, wordOf(v.hi, expIdx(k)));
            if (k == 0) check("start_low", startInput, 1'b0);
            @(negedge clk);
        end
        go = 1'b0;
        check("gap_word", inp, wordOf(v.hi, expIdx(NW - 1)));
        @(negedge clk);
        check("flush_word", inp, '0);
        check("flush_no_compute", startCompute, 1'b0);
        @(negedge clk);
        check("compute_rise", startCompute, 1'b1);
        n = 0;
        while (!getResult && n < 4 * RD) begin
            if (v.noise) ack = (n == 10);
            @(negedge clk);
            n++;
        end
        ack = 1'b0;
        hostIf.s_valid = 1'b0;
        hostIf.s_data  = '0;
        check("result_delay", n, RD);
        check("latency", cycle - tStart, v.expLat);
        for (int i = 0; i < v.ackHold; i++) begin
            check("result_hold", {getResult, startCompute, done, busy}, 4'hF);
            @(negedge clk);
        end
        ack = 1'b1;
        go  = v.goWithAck;
        @(negedge clk);
        ack = 1'b0;
        go  = 1'b0;
        check("ack_release", {getResult, startCompute, done, busy}, 4'h0);
        if (v.goWithAck) begin
            @(negedge clk);
            check("go_with_ack_ignored", {busy, hostIf.s_ready}, 2'b00);
        end
    endtask

    initial begin
        int fc;
        int bad;
        vecs[0] = '{stall: 1'b0, hi: 120'h0, ackHold: 3, noise: 1'b0,
                    goWithAck: 1'b0, expFill: NW, expLat: LAT};
        vecs[1] = '{stall: 1'b1, hi: 120'hC3C3_0000_1111_2222_3333_4444_5555_66, ackHold: 50,
                    noise: 1'b0, goWithAck: 1'b1, expFill: 2 * NW - 1, expLat: LAT};
        vecs[2] = '{stall: 1'b0, hi: 120'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_43, ackHold: 1,
                    noise: 1'b1, goWithAck: 1'b0, expFill: NW, expLat: LAT};
        vecs[3] = '{stall: 1'b1, hi: 120'h7E7E_7E7E_0101_0202_0303_0404_0505_06, ackHold: 0,
                    noise: 1'b0, goWithAck: 1'b0, expFill: 2 * NW - 1, expLat: LAT};

        hostIf.s_valid = 1'b0;
        hostIf.s_data  = '0;
        @(negedge clk);
        check("reset_strobes", {startInput, startCompute, getResult, done, busy, hostIf.s_ready}, 6'b0);
        check("reset_inp", inp, '0);
        #1 reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            runTxn(vecs[i]);
        end

        // Reset asserted in the middle of the burst must abort everything at once.
        doFill(1'b0, 120'h5A5A_0000_0000_0000_0000_0000_0000_00, fc);
        check("rst_seq_pulse", startInput, 1'b1);
        repeat (11) @(negedge clk);
        check("pre_reset_word", inp, wordOf(120'h5A5A_0000_0000_0000_0000_0000_0000_00, expIdx(10)));
        reset = 1'b0;
        #1;
        check("reset_async", {startInput, startCompute, getResult, done, busy}, 5'b0);
        check("reset_async_inp", inp, '0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (startInput || startCompute || busy || inp != '0) bad++;
        end
        check("no_resume", bad, 0);

        runTxn(vecs[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
